// File: rtl/round_controller.sv
// round_controller: per-round sequencer for the light-cycle match.
// Runs the pre-round countdown, generates move ticks, scores crashes and
// raises the strobes that move the game state machine out of Round_Started.
// Ports:
//   Clk, Reset            clock, synchronous active-high reset
//   Game_State[2:0]       0 Menu, 1 Round_Paused, 2 Round_Started, 3 Blue_Wins, 4 Red_Wins
//   blue_crash, red_crash collision levels, only looked at while running
//   move_tick             one-cycle strobe, bikes advance one cell
//   countdown_val[2:0]    seconds remaining (HUD), 0 when not counting
//   counting              high during the countdown
//   blue_score, red_score round wins in the current match
//   Blue_W, Red_W         one-cycle match-won strobes
//   Reset_Round           one-cycle round-over strobe, match continues
module round_controller #(
  parameter int TICKS_PER_SEC = 50000000,
  parameter int COUNT_SECS    = 3,
  parameter int MOVE_PERIOD   = 2000000,
  parameter int WINS_TO_MATCH = 3,
  parameter int SCORE_W       = 3
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic [2:0]         Game_State,
  input  logic               blue_crash,
  input  logic               red_crash,
  output logic               move_tick,
  output logic [2:0]         countdown_val,
  output logic               counting,
  output logic [SCORE_W-1:0] blue_score,
  output logic [SCORE_W-1:0] red_score,
  output logic               Blue_W,
  output logic               Red_W,
  output logic               Reset_Round
);
  localparam int PW = TICKS_PER_SEC > 1 ? $clog2(TICKS_PER_SEC) : 1;
  localparam int MW = $clog2(MOVE_PERIOD);
  typedef enum logic [2:0] {IDLE, COUNTDOWN, RUN, RESOLVE, WAIT_ROUND, WAIT_MENU} state_t;
  state_t            state_q;
  logic [2:0]        gs_q;
  logic [PW-1:0]     pre_q;
  logic [MW-1:0]     mv_q;
  logic              b_q, r_q;
  logic              in_round, pre_wrap, mv_wrap, blue_inc, red_inc, blue_win, red_win;
  logic [SCORE_W-1:0] blue_d, red_d;
  always_comb begin
    in_round = Game_State == 3'd2;
    pre_wrap = pre_q == PW'(TICKS_PER_SEC - 1);
    mv_wrap  = mv_q == MW'(MOVE_PERIOD - 1);
    // a crash scores a point for the other bike; a double crash is a draw
    blue_inc = r_q & ~b_q;
    red_inc  = b_q & ~r_q;
    blue_d   = (blue_inc && blue_score != '1) ? blue_score + 1'b1 : blue_score;
    red_d    = (red_inc && red_score != '1) ? red_score + 1'b1 : red_score;
    blue_win = blue_inc && blue_d == SCORE_W'(WINS_TO_MATCH);
    red_win  = red_inc && red_d == SCORE_W'(WINS_TO_MATCH);
  end
  // previous Game_State, used to detect a fresh entry into Round_Started
  always_ff @(posedge Clk) gs_q <= Game_State;
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q       <= IDLE;
      pre_q         <= '0;
      mv_q          <= '0;
      b_q           <= 1'b0;
      r_q           <= 1'b0;
      move_tick     <= 1'b0;
      countdown_val <= 3'd0;
      counting      <= 1'b0;
      blue_score    <= '0;
      red_score     <= '0;
      Blue_W        <= 1'b0;
      Red_W         <= 1'b0;
      Reset_Round   <= 1'b0;
    end else begin
      move_tick   <= 1'b0;
      Blue_W      <= 1'b0;
      Red_W       <= 1'b0;
      Reset_Round <= 1'b0;
      case (state_q)
        IDLE: begin
          if (Game_State == 3'd0) begin
            blue_score <= '0;
            red_score  <= '0;
          end
          if (in_round && gs_q != 3'd2) begin
            state_q       <= COUNTDOWN;
            countdown_val <= 3'(COUNT_SECS);
            pre_q         <= '0;
            counting      <= 1'b1;
          end
        end
        COUNTDOWN: begin
          if (!in_round) begin
            state_q       <= IDLE;
            countdown_val <= 3'd0;
            counting      <= 1'b0;
          end else if (pre_wrap) begin
            pre_q         <= '0;
            countdown_val <= countdown_val - 3'd1;
            if (countdown_val == 3'd1) begin
              state_q  <= RUN;
              counting <= 1'b0;
              mv_q     <= '0;
            end
          end else pre_q <= pre_q + 1'b1;
        end
        RUN: begin
          if (!in_round) state_q <= IDLE;
          else if (blue_crash || red_crash) begin
            b_q     <= blue_crash;
            r_q     <= red_crash;
            state_q <= RESOLVE;
          end else begin
            mv_q      <= mv_wrap ? '0 : mv_q + 1'b1;
            move_tick <= mv_wrap;
          end
        end
        RESOLVE: begin
          blue_score  <= blue_d;
          red_score   <= red_d;
          Blue_W      <= blue_win;
          Red_W       <= red_win;
          Reset_Round <= !(blue_win || red_win);
          state_q     <= (blue_win || red_win) ? WAIT_MENU : WAIT_ROUND;
        end
        WAIT_ROUND: state_q <= in_round ? WAIT_ROUND : IDLE;
        WAIT_MENU: begin
          if (Game_State == 3'd0) begin
            blue_score <= '0;
            red_score  <= '0;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_round_controller.sv
// tb_round_controller: directed and random stimulus for round_controller against a timeline model.
module tb_round_controller;
  localparam int TPS = 4, CS = 3, MP = 5, WINS = 2, SW = 3;
  localparam int SMAX = (1 << SW) - 1;
  localparam int M_IDLE = 0, M_CD = 1, M_RUN = 2, M_RES = 3, M_WR = 4, M_WM = 5;
  logic          Clk = 1'b0, Reset = 1'b1, blue_crash = 1'b0, red_crash = 1'b0;
  logic [2:0]    Game_State = 3'd0;
  logic          move_tick, counting, Blue_W, Red_W, Reset_Round;
  logic [2:0]    countdown_val;
  logic [SW-1:0] blue_score, red_score;
  int checks = 0, fails = 0;
  int m_mode = M_IDLE, m_t = 0, m_bs = 0, m_rs = 0, m_pg = 0;
  bit m_lb, m_lr;
  int e_tick, e_cd, e_cnt, e_bw, e_rw, e_rr;
  round_controller #(.TICKS_PER_SEC(TPS), .COUNT_SECS(CS), .MOVE_PERIOD(MP),
                     .WINS_TO_MATCH(WINS), .SCORE_W(SW)) dut (
    .Clk(Clk), .Reset(Reset), .Game_State(Game_State), .blue_crash(blue_crash),
    .red_crash(red_crash), .move_tick(move_tick), .countdown_val(countdown_val),
    .counting(counting), .blue_score(blue_score), .red_score(red_score),
    .Blue_W(Blue_W), .Red_W(Red_W), .Reset_Round(Reset_Round));
  always #5 Clk = ~Clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  // Timeline model: countdown value and tick timing come from elapsed cycles
  // since the mode was entered, scores from the round outcome rules.
  task automatic model(input bit rst, input int gs, input bit bc, input bit rc);
    e_tick = 0; e_bw = 0; e_rw = 0; e_rr = 0;
    if (rst) begin
      m_mode = M_IDLE; m_bs = 0; m_rs = 0;
    end else if (m_mode == M_IDLE) begin
      if (gs == 0) begin m_bs = 0; m_rs = 0; end
      if (gs == 2 && m_pg != 2) begin m_mode = M_CD; m_t = 0; end
    end else if (m_mode == M_CD) begin
      if (gs != 2) m_mode = M_IDLE;
      else begin
        m_t++;
        if (m_t == CS * TPS) begin m_mode = M_RUN; m_t = 0; end
      end
    end else if (m_mode == M_RUN) begin
      if (gs != 2) m_mode = M_IDLE;
      else if (bc || rc) begin m_lb = bc; m_lr = rc; m_mode = M_RES; end
      else begin m_t++; e_tick = (m_t % MP == 0); end
    end else if (m_mode == M_RES) begin
      if (m_lr && !m_lb) m_bs = (m_bs + 1 > SMAX) ? SMAX : m_bs + 1;
      if (m_lb && !m_lr) m_rs = (m_rs + 1 > SMAX) ? SMAX : m_rs + 1;
      if (m_lr && !m_lb && m_bs == WINS) begin e_bw = 1; m_mode = M_WM; end
      else if (m_lb && !m_lr && m_rs == WINS) begin e_rw = 1; m_mode = M_WM; end
      else begin e_rr = 1; m_mode = M_WR; end
    end else if (m_mode == M_WR) begin
      if (gs != 2) m_mode = M_IDLE;
    end else if (m_mode == M_WM) begin
      if (gs == 0) begin m_bs = 0; m_rs = 0; m_mode = M_IDLE; end
    end
    e_cnt = (m_mode == M_CD);
    e_cd = (m_mode == M_CD) ? CS - m_t / TPS : 0;
    m_pg = gs;
  endtask
  task automatic step(input bit rst, input logic [2:0] gs, input bit bc, input bit rc);
    Reset = rst; Game_State = gs; blue_crash = bc; red_crash = rc;
    @(posedge Clk);
    model(rst, int'(gs), bc, rc);
    @(negedge Clk);
    chk("move_tick", move_tick, e_tick);
    chk("countdown_val", countdown_val, e_cd);
    chk("counting", counting, e_cnt);
    chk("blue_score", blue_score, m_bs);
    chk("red_score", red_score, m_rs);
    chk("Blue_W", Blue_W, e_bw);
    chk("Red_W", Red_W, e_rw);
    chk("Reset_Round", Reset_Round, e_rr);
    chk("strobe_exclusive", 32'(Blue_W) + 32'(Red_W) + 32'(Reset_Round) <= 1, 1);
  endtask
  task automatic play_round(input bit bc, input bit rc);
    step(0, 3'd1, 0, 0);
    for (int i = 0; i < 14; i++) step(0, 3'd2, 0, 0);
    step(0, 3'd2, bc, rc);
    for (int i = 0; i < 3; i++) step(0, 3'd2, 0, 0);
  endtask
  initial begin
    int first_cnt, first_tick, bw_pulses, rr_pulses;
    logic [2:0] gs;
    @(negedge Clk);
    for (int i = 0; i < 3; i++) step(1, 3'd0, 0, 0);
    chk("reset_blue", blue_score, 0);
    chk("reset_cd", countdown_val, 0);
    step(0, 3'd1, 0, 0);
    step(0, 3'd1, 0, 0);
    first_cnt = -1; first_tick = -1;
    for (int i = 0; i < 30; i++) begin
      step(0, 3'd2, 0, 0);
      if (first_cnt < 0 && counting) first_cnt = i;
      if (first_tick < 0 && move_tick) first_tick = i;
    end
    chk("first_tick_offset", first_tick - first_cnt, 17);
    step(0, 3'd2, 0, 1);
    step(0, 3'd2, 0, 0);
    chk("s2_blue_score", blue_score, 1);
    chk("s2_reset_round", Reset_Round, 1);
    for (int i = 0; i < 8; i++) step(0, 3'd2, 0, 0);
    step(0, 3'd1, 0, 0);
    step(0, 3'd1, 0, 0);
    chk("s2_idle_keeps_score", blue_score, 1);
    play_round(1, 0);
    chk("s3_red_score", red_score, 1);
    step(0, 3'd1, 0, 0);
    for (int i = 0; i < 14; i++) step(0, 3'd2, 0, 0);
    step(0, 3'd2, 0, 1);
    bw_pulses = 0; rr_pulses = 0;
    for (int i = 0; i < 4; i++) begin
      step(0, 3'd2, 0, 0);
      bw_pulses += int'(Blue_W);
      rr_pulses += int'(Reset_Round);
    end
    chk("s3_blue_w_pulses", bw_pulses, 1);
    chk("s3_no_reset_round", rr_pulses, 0);
    chk("s3_blue_score", blue_score, 2);
    for (int i = 0; i < 4; i++) step(0, 3'd3, 0, 0);
    chk("s3_wait_menu_holds", blue_score, 2);
    step(0, 3'd0, 0, 0);
    step(0, 3'd0, 0, 0);
    chk("s3_menu_clears_blue", blue_score, 0);
    chk("s3_menu_clears_red", red_score, 0);
    step(0, 3'd1, 0, 0);
    for (int i = 0; i < 14; i++) step(0, 3'd2, 0, 0);
    step(0, 3'd2, 1, 1);
    step(0, 3'd2, 0, 0);
    chk("s4_draw_reset_round", Reset_Round, 1);
    chk("s4_draw_no_blue_w", Blue_W, 0);
    chk("s4_draw_blue_score", blue_score, 0);
    step(0, 3'd1, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 3'd2, 0, 0);
    step(0, 3'd2, 1, 1);
    chk("s5_cd_two", countdown_val, 2);
    step(0, 3'd0, 0, 0);
    chk("s5_abort_cd", countdown_val, 0);
    chk("s5_abort_counting", counting, 0);
    play_round(0, 1);
    chk("s6_blue_before_reset", blue_score, 1);
    step(0, 3'd1, 0, 0);
    for (int i = 0; i < 14; i++) step(0, 3'd2, 0, 0);
    step(1, 3'd2, 0, 0);
    chk("s6_reset_blue", blue_score, 0);
    chk("s6_reset_tick", move_tick, 0);
    step(0, 3'd1, 0, 0);
    step(0, 3'd2, 0, 0);
    chk("s6_restart_cd", countdown_val, 3);
    gs = 3'd2;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(59) == 0) gs = 3'($urandom_range(4));
      step($urandom_range(499) == 0, gs, $urandom_range(15) == 0, $urandom_range(15) == 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
